// File: rtl/board_io_pkg.sv
// Shared definitions for the board input conditioner.
//   ch_state_e  : per-channel debounce state (stable low/high, waiting for high/low).
//   clog2_width : ceil(log2(value)) with a floor of 1, for sizing counters from parameters.
package board_io_pkg;

  typedef enum logic [1:0] {
    StStableLo = 2'd0,
    StWaitHi   = 2'd1,
    StStableHi = 2'd2,
    StWaitLo   = 2'd3
  } ch_state_e;

  // Smallest w with 2**w >= value; never returns 0 so it can size a vector directly.
  function automatic int unsigned clog2_width(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        w = i + 1;
      end
    end
    if (w == 0) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/board_input_conditioner_if.sv
// Bundle of the conditioner's board-side and downstream-side signals.
//   raw_i   : unsynchronised, bouncing button/switch inputs
//   level_o : debounced level per channel
//   rise_o  : one-cycle pulse on an accepted 0->1 change
//   fall_o  : one-cycle pulse on an accepted 1->0 change
//   reset_o : conditioned active-high reset for downstream logic
// slave  : the conditioner's view (drives the outputs)
// master : the environment's view (drives raw_i)
interface board_input_conditioner_if #(
  parameter int unsigned NUM_CH = 4
) ();

  logic [NUM_CH-1:0] raw_i;
  logic [NUM_CH-1:0] level_o;
  logic [NUM_CH-1:0] rise_o;
  logic [NUM_CH-1:0] fall_o;
  logic              reset_o;

  modport master (
    output raw_i,
    input  level_o,
    input  rise_o,
    input  fall_o,
    input  reset_o
  );

  modport slave (
    input  raw_i,
    output level_o,
    output rise_o,
    output fall_o,
    output reset_o
  );

endinterface

// File: rtl/debounce_channel.sv
// One debounced input channel: SYNC_STAGES-deep synchroniser, four-state debounce FSM with a
// saturating stability counter, and registered level/edge-pulse outputs.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   raw_i   : raw (asynchronous, bouncing) input
//   level_o : accepted level
//   rise_o  : one-cycle pulse when a 0->1 change is accepted
//   fall_o  : one-cycle pulse when a 1->0 change is accepted
// Edge-to-level latency is SYNC_STAGES + DEBOUNCE_CYCLES cycles. SYNC_STAGES >= 2 and
// DEBOUNCE_CYCLES >= 2 are assumed.
module debounce_channel
  import board_io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = clog2_width(DEBOUNCE_CYCLES + 1);
  // The sample that moves the FSM into a WAIT state is the first of the DEBOUNCE_CYCLES
  // stable samples, so acceptance happens once the counter has seen DEBOUNCE_CYCLES-2 more.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic                   sync_in;

  ch_state_e       state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            level_d, level_q;
  logic            rise_d, rise_q;
  logic            fall_d, fall_q;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
  assign sync_in = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StStableLo: begin
        if (sync_in) begin
          state_d = StWaitHi;
          cnt_d   = '0;
        end
      end
      StWaitHi: begin
        if (!sync_in) begin
          // Bounce: drop back without touching the outputs.
          state_d = StStableLo;
          cnt_d   = '0;
        end else if (cnt_q >= CntLast) begin
          state_d = StStableHi;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStableHi: begin
        if (!sync_in) begin
          state_d = StWaitLo;
          cnt_d   = '0;
        end
      end
      StWaitLo: begin
        if (sync_in) begin
          state_d = StStableHi;
          cnt_d   = '0;
        end else if (cnt_q >= CntLast) begin
          state_d = StStableLo;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StStableLo;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      state_q <= StStableLo;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/board_input_conditioner.sv
// Board input conditioner: NUM_CH independent debounced button/switch channels plus a
// conditioned system reset.
//   clk_50MHz_i : system clock (single domain)
//   reset_async : asynchronous active-high board reset
//   bus         : slave side of board_input_conditioner_if
//                 (raw_i in; level_o, rise_o, fall_o, reset_o out)
// reset_o asserts asynchronously with reset_async and deasserts synchronously RESET_HOLD + 2
// rising edges after reset_async falls (two-flop synchroniser, then hold counter). A new
// reset_async pulse at any point restarts the whole sequence. The channels are reset by
// reset_async directly, so they start debouncing as soon as the board reset releases.
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RESET_HOLD      = 16
) (
  input logic                      clk_50MHz_i,
  input logic                      reset_async,
  board_input_conditioner_if.slave bus
);

  localparam int unsigned HoldW = clog2_width(RESET_HOLD + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD - 1);

  // ---------------------------------------------------------------------------------------
  // Reset conditioning
  // ---------------------------------------------------------------------------------------
  logic [1:0]       rst_sync_d, rst_sync_q;
  logic [HoldW-1:0] hold_cnt_d, hold_cnt_q;
  logic             reset_d, reset_q;

  // Shift zeros in; the synchronised reset is the upper bit.
  assign rst_sync_d = {rst_sync_q[0], 1'b0};

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    reset_d    = reset_q;
    if (rst_sync_q[1]) begin
      hold_cnt_d = '0;
      reset_d    = 1'b1;
    end else if (reset_q) begin
      if (hold_cnt_q >= HoldLast) begin
        reset_d = 1'b0;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50MHz_i or posedge reset_async) begin
    if (reset_async) begin
      rst_sync_q <= 2'b11;
      hold_cnt_q <= '0;
      reset_q    <= 1'b1;
    end else begin
      rst_sync_q <= rst_sync_d;
      hold_cnt_q <= hold_cnt_d;
      reset_q    <= reset_d;
    end
  end

  assign bus.reset_o = reset_q;

  // ---------------------------------------------------------------------------------------
  // Debounce channels
  // ---------------------------------------------------------------------------------------
  logic [NUM_CH-1:0] level_w;
  logic [NUM_CH-1:0] rise_w;
  logic [NUM_CH-1:0] fall_w;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i  (clk_50MHz_i),
      .rst_i  (reset_async),
      .raw_i  (bus.raw_i[g]),
      .level_o(level_w[g]),
      .rise_o (rise_w[g]),
      .fall_o (fall_w[g])
    );
  end

  assign bus.level_o = level_w;
  assign bus.rise_o  = rise_w;
  assign bus.fall_o  = fall_w;

endmodule

// File: doc/board_input_conditioner.md
BOARD_INPUT_CONDITIONER -- requirements
Module: board_input_conditioner

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent button/switch channels.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: flip-flop synchroniser depth per channel.
REQ-003 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), minimum 2: clock cycles an input must stay stable before it is accepted.
REQ-004 Parameter RESET_HOLD, default 16, minimum 1: clock cycles reset_o is held after reset_async deasserts.
REQ-005 clk_50MHz_i  input  1  system clock; one clock domain only.
REQ-006 reset_async  input  1  asynchronous, active-high reset.
REQ-007 raw_i  input  NUM_CH  unsynchronised, bouncing board inputs (buttons and switches).
REQ-008 level_o  output  NUM_CH  debounced stable level per channel.
REQ-009 rise_o  output  NUM_CH  one-cycle pulse on an accepted 0->1 change.
REQ-010 fall_o  output  NUM_CH  one-cycle pulse on an accepted 1->0 change.
REQ-011 reset_o  output  1  conditioned active-high reset for downstream logic (CPU core, UART, display).

Function
REQ-012 Each channel SHALL pass raw_i through SYNC_STAGES flip-flops before any other use; only the last stage drives the debounce FSM.
REQ-013 Each channel SHALL implement four states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-014 In STABLE_LO, sync input 1 SHALL move to WAIT_HI with the counter cleared; in STABLE_HI, sync input 0 SHALL move to WAIT_LO with the counter cleared.
REQ-015 In WAIT_HI/WAIT_LO, a sync input returning to the old level SHALL return to the previous stable state with no output change and no pulse (bounce rejection).
REQ-016 In WAIT_HI/WAIT_LO, when the sync input has held the new level for DEBOUNCE_CYCLES consecutive cycles, the channel SHALL enter the new stable state, update level_o, and pulse rise_o or fall_o for exactly one cycle.
REQ-017 Latency from a clean raw_i edge to level_o change SHALL be exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles; rise_o/fall_o SHALL be asserted in the same cycle level_o changes.
REQ-018 Counter width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits; the counter SHALL saturate, never wrap, and SHALL only count in WAIT states.
REQ-019 rise_o and fall_o of one channel SHALL never be asserted together; channels SHALL be fully independent, and simultaneous changes on several channels SHALL each produce their own pulse in the same cycle.
REQ-020 reset_o SHALL assert asynchronously in the same instant reset_async rises and deassert synchronously, exactly RESET_HOLD + 2 rising edges after reset_async falls (2-stage reset synchroniser plus hold counter).
REQ-021 A reset_async pulse during a hold count SHALL re-assert reset_o immediately and restart the full hold sequence.

Reset
REQ-022 While reset_async is 1: all channel FSMs in STABLE_LO, counters 0, synchroniser flops 0, level_o = 0, rise_o = 0, fall_o = 0, reset_o = 1.
REQ-023 Reset mid-debounce SHALL discard the pending transition; a channel whose input is high after reset SHALL produce rise_o after the full REQ-017 latency.

Structure
REQ-024 Shared package board_io_pkg SHALL hold the channel state enumeration and the clog2 width helper.
REQ-025 One sub-module debounce_channel (synchroniser, FSM, counter, pulse generation) SHALL be instantiated NUM_CH times by a generate loop; the reset synchroniser and hold counter SHALL live in the top module.

Verification
REQ-026 NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4: raw_i[0] 0->1 held -> level_o[0]=1 and rise_o[0] one-cycle pulse exactly 6 cycles after the edge.
REQ-027 raw_i[1] toggles 1,0,1,0 every 2 cycles then held 1 -> no pulse during bouncing; single rise_o[1] 6 cycles after final stable edge.
REQ-028 raw_i[3:0] = 4'b1111 in one cycle -> rise_o = 4'b1111 in one common cycle; later 4'b0000 -> fall_o = 4'b1111 once.
REQ-029 RESET_HOLD=16: reset_async high 3 cycles then low -> reset_o high immediately, low after exactly 18 rising edges.
REQ-030 reset_async pulsed at cycle 2 of a WAIT_HI count on channel 2 -> level_o[2]=0, no pulse; with input still high, rise_o[2] 6 cycles after reset release.
REQ-031 reset_async re-pulsed at hold cycle 10 -> reset_o stays high, deasserts 18 edges after the second release.
